// File: rtl/sin_ft_pkg.sv
// Shared definitions for the sine fault-sensitivity sequencer: widths, MISR
// defaults, FSM encoding and the operand-vector schedule.
package sin_ft_pkg;

    localparam int A_W = 24;
    localparam int S_W = 25;

    localparam logic [S_W-1:0] MISR_POLY_DEF = 25'h0000009;
    localparam logic [S_W-1:0] MISR_SEED_DEF = 25'h0000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sin_state_e;

    // Next operand for step i; groups that are not due for an update keep a_prev.
    function automatic logic [A_W-1:0] sin_vec_next(
        input logic [7:0]     i,
        input logic [A_W-1:0] a_prev,
        input int             mid_log2 = 5,
        input int             low_log2 = 6
    );
        logic [A_W-1:0] a;
        logic [7:0]     mid_mask;
        logic [7:0]     low_mask;
        a        = a_prev;
        mid_mask = (mid_log2 >= 8) ? 8'hFF : 8'((9'd1 << mid_log2) - 9'd1);
        low_mask = (low_log2 >= 8) ? 8'hFF : 8'((9'd1 << low_log2) - 9'd1);
        if (i[0] == 1'b0) begin
            a[0] = i[1];
        end else begin
            a[0] = a_prev[0];
        end
        a[6:1] = i[7:2];
        a[7]   = i[3] ^ i[4];
        if ((i & mid_mask) == 8'd0) begin
            a[15:8] = {i[7] ^ i[5], i[6] ^ i[4], i[5] ^ i[3], i[4] ^ i[2],
                       i[6], i[5], i[4], i[3]};
        end else begin
            a[15:8] = a_prev[15:8];
        end
        if ((i & low_mask) == 8'd0) begin
            a[23:16] = i;
        end else begin
            a[23:16] = a_prev[23:16];
        end
        return a;
    endfunction

endpackage

// File: rtl/sin_misr.sv
// Multiple-input signature register: Galois-style shift with POLY feedback,
// seeded by load and advanced by en.
module sin_misr #(
    parameter int           W       = 25,
    parameter logic [W-1:0] POLY    = 25'h0000009,
    parameter logic [W-1:0] RST_VAL = 25'h0000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] r_sig;

    // Signature state: seed load wins over a concurrent fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= RST_VAL;
        end else if (load) begin
            r_sig <= seed;
        end else if (en) begin
            r_sig <= {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : {W{1'b0}}) ^ din;
        end else begin
            r_sig <= r_sig;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/sin_stim_scheduler.sv
// Sequencer for the 24-bit sine netlist: schedules operand vectors, waits a
// settle window, captures each result and folds it into a MISR signature.
module sin_stim_scheduler
    import sin_ft_pkg::*;
#(
    parameter int             SETTLE_CYCLES = 2,
    parameter int             MID_LOG2      = 5,
    parameter int             LOW_LOG2      = 6,
    parameter logic [S_W-1:0] MISR_POLY     = MISR_POLY_DEF,
    parameter logic [S_W-1:0] MISR_SEED     = MISR_SEED_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [8:0]     steps,
    output logic [A_W-1:0] dut_a,
    input  logic [S_W-1:0] dut_sin,
    output logic           busy,
    output logic           done,
    output logic           cap_valid,
    output logic [S_W-1:0] cap_data,
    output logic [7:0]     step_idx,
    output logic [S_W-1:0] signature
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : {CNT_W{1'b0}};

    sin_state_e       r_state;
    sin_state_e       w_next_fsm;
    sin_state_e       w_next_state;
    logic [8:0]       r_steps;
    logic [7:0]       r_i;
    logic [A_W-1:0]   r_dut_a;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_cap_valid;
    logic [S_W-1:0]   r_cap_data;

    logic w_accept;
    logic w_capture;
    logic w_last;

    assign w_accept  = (r_state == ST_IDLE) && start && !abort;
    assign w_capture = (r_state == ST_CAPTURE) && !abort;
    // 9-bit compare so steps = 256 ends at i = 255 without wrapping i.
    assign w_last    = (({1'b0, r_i} + 9'd1) == r_steps);

    // Next-state decode; abort from any active state overrides the schedule.
    always_comb begin
        w_next_fsm = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_fsm = (steps == 9'd0) ? ST_DONE : ST_APPLY;
                end else begin
                    w_next_fsm = ST_IDLE;
                end
            end
            ST_APPLY:   w_next_fsm = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_next_fsm = ST_CAPTURE;
                end else begin
                    w_next_fsm = ST_SETTLE;
                end
            end
            ST_CAPTURE: w_next_fsm = w_last ? ST_DONE : ST_APPLY;
            ST_DONE:    w_next_fsm = ST_IDLE;
            default:    w_next_fsm = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end else begin
            w_next_state = w_next_fsm;
        end
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_data  <= {S_W{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
            r_cap_valid <= w_capture;
            r_cap_data  <= w_capture ? dut_sin : r_cap_data;
        end
    end

    // Step counter, run length and operand vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps <= 9'd0;
            r_i     <= 8'd0;
            r_dut_a <= {A_W{1'b0}};
        end else if (w_accept) begin
            r_steps <= steps;
            r_i     <= 8'd0;
            r_dut_a <= {A_W{1'b0}};
        end else if ((r_state == ST_APPLY) && !abort) begin
            r_dut_a <= sin_vec_next(r_i, r_dut_a, MID_LOG2, LOW_LOG2);
        end else if (w_capture && !w_last) begin
            r_i <= r_i + 8'd1;
        end else begin
            r_i <= r_i;
        end
    end

    // Settle window counter, cleared whenever the FSM is outside SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_settle_cnt <= {CNT_W{1'b0}};
        end
    end

    sin_misr #(
        .W       (S_W),
        .POLY    (MISR_POLY),
        .RST_VAL (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .seed  (MISR_SEED),
        .en    (w_capture),
        .din   (dut_sin),
        .sig   (signature)
    );

    assign dut_a     = r_dut_a;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cap_valid = r_cap_valid;
    assign cap_data  = r_cap_data;
    assign step_idx  = r_i;

endmodule

// File: tb/tb_sin_stim_scheduler.sv
// Directed bench for sin_stim_scheduler: a table of constant-result runs plus
// hand-written loopback, abort, start/abort-collision and mid-run reset cases.
module tb_sin_stim_scheduler;
    import sin_ft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [8:0]  steps;
    logic [23:0] dut_a;
    logic [24:0] dut_sin;
    logic        busy;
    logic        done;
    logic        cap_valid;
    logic [24:0] cap_data;
    logic [7:0]  step_idx;
    logic [24:0] signature;

    logic        loop_en;
    logic [24:0] sin_const;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [8:0]  n;
        logic [24:0] sinv;
        logic [24:0] exp_sig;
        logic [24:0] exp_cap;
        logic [15:0] exp_caps;
        logic [15:0] exp_done;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    assign dut_sin = loop_en ? {1'b0, dut_a} : sin_const;

    sin_stim_scheduler #(
        .SETTLE_CYCLES (2),
        .MID_LOG2      (5),
        .LOW_LOG2      (6),
        .MISR_POLY     (25'h0000009),
        .MISR_SEED     (25'h0000000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .steps     (steps),
        .dut_a     (dut_a),
        .dut_sin   (dut_sin),
        .busy      (busy),
        .done      (done),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .step_idx  (step_idx),
        .signature (signature)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] misr_step(input logic [24:0] s, input logic [24:0] d);
        return {s[23:0], 1'b0} ^ (s[24] ? 25'h0000009 : 25'h0000000) ^ d;
    endfunction

    // One complete run; done_cyc counts cycles after the accept edge (-1 on timeout).
    task automatic run(input logic [8:0] n, output int done_cyc, output int caps,
                       output logic [24:0] last_cap);
        done_cyc = -1;
        caps     = 0;
        last_cap = 25'h0;
        @(negedge clk);
        steps = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (cap_valid) begin
                caps++;
                last_cap = cap_data;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          dcyc;
        int          caps;
        int          mism;
        int          a0_bad;
        int          done_seen;
        logic [24:0] lcap;
        logic [24:0] sig_m;
        logic [23:0] a_m;
        logic        prev_a0;

        tbl[0] = '{9'd1, 25'h0000001, 25'h0000001, 25'h0000001, 16'd1, 16'd5};
        tbl[1] = '{9'd2, 25'h0000001, 25'h0000003, 25'h0000001, 16'd2, 16'd9};
        tbl[2] = '{9'd0, 25'h0000001, 25'h0000000, 25'h0000000, 16'd0, 16'd1};
        tbl[3] = '{9'd3, 25'h1000000, 25'h100001B, 25'h1000000, 16'd3, 16'd13};
        tbl[4] = '{9'd4, 25'h0AAAAAA, 25'h000001D, 25'h0AAAAAA, 16'd4, 16'd17};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        steps     = 9'd0;
        loop_en   = 1'b0;
        sin_const = 25'h0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_capv", {31'd0, cap_valid}, 32'd0);
        chk("rst_dut_a", {8'd0, dut_a}, 32'd0);
        chk("rst_sig", {7'd0, signature}, 32'd0);
        chk("rst_idx", {24'd0, step_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            sin_const = tbl[v].sinv;
            run(tbl[v].n, dcyc, caps, lcap);
            chk($sformatf("tbl%0d_done_cyc", v), dcyc, {16'd0, tbl[v].exp_done});
            chk($sformatf("tbl%0d_caps", v), caps, {16'd0, tbl[v].exp_caps});
            chk($sformatf("tbl%0d_cap_data", v), {7'd0, lcap}, {7'd0, tbl[v].exp_cap});
            chk($sformatf("tbl%0d_sig", v), {7'd0, signature}, {7'd0, tbl[v].exp_sig});
            @(negedge clk);
            chk($sformatf("tbl%0d_busy_after", v), {31'd0, busy}, 32'd0);
        end

        // start together with abort in IDLE must be ignored: no reload, no run
        @(negedge clk);
        steps = 9'd5;
        start = 1'b1;
        abort = 1'b1;
        done_seen = 0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (busy || done) done_seen++;
            @(negedge clk);
        end
        chk("start_abort_idle", done_seen, 0);
        chk("start_abort_sig", {7'd0, signature}, 32'h000001D);

        // 128-step loopback with a start pulse in mid-run that must be ignored
        loop_en = 1'b1;
        a_m     = 24'h0;
        sig_m   = 25'h0;
        mism    = 0;
        a0_bad  = 0;
        prev_a0 = 1'b0;
        caps    = 0;
        dcyc    = -1;
        @(negedge clk);
        steps = 9'd128;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            start = (k == 100);
            if (cap_valid) begin
                a_m   = sin_vec_next(8'(caps), a_m);
                sig_m = misr_step(sig_m, {1'b0, a_m});
                if (cap_data !== {1'b0, a_m}) mism++;
                if ((caps % 2 == 1) && (cap_data[0] !== prev_a0)) a0_bad++;
                prev_a0 = cap_data[0];
                if (caps == 5)  chk("loop_a_i5",  {7'd0, cap_data}, 32'h000002);
                if (caps == 32) chk("loop_a_i32", {7'd0, cap_data}, 32'h00A410);
                if (caps == 64) chk("loop_a_i64", {7'd0, cap_data}, 32'h404820);
                caps++;
            end
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start = 1'b0;
        chk("loop_done_cyc", dcyc, 513);
        chk("loop_caps", caps, 128);
        chk("loop_model_mism", mism, 0);
        chk("loop_a0_odd_hold", a0_bad, 0);
        chk("loop_sig", {7'd0, signature}, {7'd0, sig_m});
        loop_en = 1'b0;

        // abort in SETTLE of step 10: partial signature held, no done pulse
        sin_const = 25'h0000001;
        done_seen = 0;
        caps      = 0;
        @(negedge clk);
        steps = 9'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cap_valid) caps++;
            if (done) done_seen++;
            if (step_idx == 8'd10) break;
        end
        chk("abort_reach_i10", {24'd0, step_idx}, 32'd10);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        sig_m = 25'h0;
        for (int k = 0; k < 10; k++) sig_m = misr_step(sig_m, 25'h0000001);
        chk("abort_sig_held", {7'd0, signature}, {7'd0, sig_m});
        for (int k = 0; k < 4; k++) begin
            if (done || busy || cap_valid) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_caps", caps, 10);
        @(negedge clk);
        steps = 9'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("rearm_idx", {24'd0, step_idx}, 32'd0);
        chk("rearm_seed", {7'd0, signature}, 32'd0);
        dcyc = -1;
        for (int k = 2; k <= 50; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = k;
                break;
            end
        end
        chk("rearm_done_cyc", dcyc, 5);
        chk("rearm_sig", {7'd0, signature}, 32'd1);

        // asynchronous reset during CAPTURE of step 3
        @(negedge clk);
        steps = 9'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (step_idx == 8'd3) break;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("prereset_dut_a", {8'd0, dut_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_capv", {31'd0, cap_valid}, 32'd0);
        chk("arst_dut_a", {8'd0, dut_a}, 32'd0);
        chk("arst_sig", {7'd0, signature}, 32'd0);
        chk("arst_idx", {24'd0, step_idx}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
